// File: rtl/player_pkg.sv
// Shared constants and types for the player controller.
package player_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_FIRE  = 8'd44;

    localparam int SHAPE_CIRCLE = 0;
    localparam int SHAPE_SQUARE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } player_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RESET_VAL sets the assumed previous level,
// so a level already high when reset releases is not reported as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sig_d <= RESET_VAL;
            rise  <= 1'b0;
        end else begin
            sig_d <= sig;
            rise  <= sig & ~sig_d;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player controller: frame-rate movement with wall clamp, fire cooldown and
// circle/square hit shape. Define PLAYER_ACCEL_EN to build the speed ramp.
//
// state    | meaning
// ST_IDLE  | no movement key held, speed 0
// ST_LEFT  | moving toward X_MIN
// ST_RIGHT | moving toward X_MAX
module player_ctrl
    import player_pkg::*;
#(
    parameter int X_CENTER      = 320,
    parameter int Y_POS         = 450,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int X_STEP        = 3,
    parameter int SIZE          = 4,
    parameter int SHAPE         = 0,
    parameter int ACCEL_FRAMES  = 4,
    parameter int FIRE_COOLDOWN = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] player_X_Pos,
    output logic [9:0] player_Y_Pos,
    output logic       is_player,
    output logic       fire,
    output logic       moving
);

    localparam logic signed [10:0] POS_LO  = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] POS_HI  = 11'(X_MAX - SIZE);
    localparam logic [3:0]         STEP    = 4'(X_STEP);
    localparam logic [7:0]         CD_LOAD = 8'(FIRE_COOLDOWN);

    logic                frame_tick;
    player_state_t       state;
    player_state_t       nxt_state;
    logic [3:0]          nxt_speed;
    logic [7:0]          cooldown;
    logic signed [10:0]  cur_pos;
    logic signed [10:0]  sum_pos;
    logic signed [10:0]  nxt_pos;

`ifdef PLAYER_ACCEL_EN
    localparam logic [7:0] ACCEL_RELOAD = 8'(ACCEL_FRAMES - 1);
    logic [3:0] speed;
    logic [7:0] accel_cnt;
    logic [7:0] nxt_accel;
`endif

    rise_detect #(.RESET_VAL(1'b1)) u_frame_rise (
        .Clk   (Clk),
        .Reset (Reset),
        .sig   (frame_clk),
        .rise  (frame_tick)
    );

    always_comb begin
        nxt_state = ST_IDLE;
        if (keycode == KEY_LEFT)
            nxt_state = ST_LEFT;
        else if (keycode == KEY_RIGHT)
            nxt_state = ST_RIGHT;

`ifdef PLAYER_ACCEL_EN
        // accel_cnt counts down the frames left before the next speed step
        nxt_accel = ACCEL_RELOAD;
        if (nxt_state == ST_IDLE)
            nxt_speed = 4'd0;
        else if (nxt_state != state)
            nxt_speed = 4'd1;
        else if (accel_cnt == 8'd0)
            nxt_speed = (speed >= STEP) ? STEP : speed + 4'd1;
        else begin
            nxt_speed = speed;
            nxt_accel = accel_cnt - 8'd1;
        end
`else
        nxt_speed = (nxt_state == ST_IDLE) ? 4'd0 : STEP;
`endif

        cur_pos = signed'({1'b0, player_X_Pos});
        sum_pos = cur_pos;
        if (nxt_state == ST_LEFT)
            sum_pos = cur_pos - signed'({7'd0, nxt_speed});
        else if (nxt_state == ST_RIGHT)
            sum_pos = cur_pos + signed'({7'd0, nxt_speed});

        nxt_pos = sum_pos;
        if (sum_pos < POS_LO)
            nxt_pos = POS_LO;
        else if (sum_pos > POS_HI)
            nxt_pos = POS_HI;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_IDLE;
            player_X_Pos <= 10'(X_CENTER);
            cooldown     <= 8'd0;
            fire         <= 1'b0;
            moving       <= 1'b0;
`ifdef PLAYER_ACCEL_EN
            speed        <= 4'd0;
            accel_cnt    <= ACCEL_RELOAD;
`endif
        end else begin
            fire <= 1'b0;
            if (frame_tick) begin
                state        <= nxt_state;
                player_X_Pos <= nxt_pos[9:0];
                moving       <= (nxt_state != ST_IDLE);
`ifdef PLAYER_ACCEL_EN
                speed        <= nxt_speed;
                accel_cnt    <= nxt_accel;
`endif
                if (keycode == KEY_FIRE && cooldown == 8'd0) begin
                    fire     <= 1'b1;
                    cooldown <= CD_LOAD;
                end else if (cooldown != 8'd0) begin
                    cooldown <= cooldown - 8'd1;
                end
            end
        end
    end

    assign player_Y_Pos = 10'(Y_POS);

    logic signed [10:0] dist_x, dist_y, abs_x, abs_y;
    logic signed [21:0] dx_w, dy_w, dist_sq;

    // Signed distances keep pixels left of column 0 from wrapping into range
    always_comb begin
        dist_x  = signed'({1'b0, DrawX}) - signed'({1'b0, player_X_Pos});
        dist_y  = signed'({1'b0, DrawY}) - signed'({1'b0, player_Y_Pos});
        abs_x   = (dist_x < 0) ? -dist_x : dist_x;
        abs_y   = (dist_y < 0) ? -dist_y : dist_y;
        dx_w    = 22'(dist_x);
        dy_w    = 22'(dist_y);
        dist_sq = dx_w * dx_w + dy_w * dy_w;
        if (SHAPE == SHAPE_SQUARE)
            is_player = (abs_x <= 11'(SIZE)) && (abs_y <= 11'(SIZE));
        else
            is_player = (dist_sq <= 22'(SIZE * SIZE));
    end

endmodule
